// File: rtl/if_fetch_stage_if.sv
// Bundle between the fetch stage and its neighbours: IF/ID handshake, redirect input
// and the instruction SRAM-like bus.
interface if_fetch_stage_if;
  // IF/ID handshake: an entry moves downstream on a rising clk edge where
  // o_if_valid & i_if_ready are both 1; while o_if_valid=1 and i_if_ready=0 all
  // o_if_* stay stable. The SRAM bus accepts a request on a cycle with
  // inst_sram_req & inst_sram_addr_ok, and returns its data on a later cycle
  // with inst_sram_data_ok.
  logic        i_if_ready;
  logic        o_if_valid;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_inst;
  logic        o_if_adef;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [1:0]  dbg_state;

  modport master (
    input  i_if_ready, i_redirect, i_redirect_pc,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output o_if_valid, o_if_pc, o_if_inst, o_if_adef,
    output inst_sram_req, inst_sram_addr, dbg_state
  );

  modport slave (
    output i_if_ready, i_redirect, i_redirect_pc,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  o_if_valid, o_if_pc, o_if_inst, o_if_adef,
    input  inst_sram_req, inst_sram_addr, dbg_state
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues one SRAM request at a time and
// holds the returned instruction in a one-entry buffer for the IF/ID register.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000,
  parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
  input logic            clk,
  input logic            rst,
  if_fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc_r, pc_n;
  logic        cancel_r, cancel_n;
  logic [31:0] out_pc, out_pc_n;
  logic [31:0] out_inst, out_inst_n;
  logic        out_adef, out_adef_n;
  logic        misaligned;
  logic        req;

  assign misaligned = (pc_r[1:0] != 2'b00);
  assign req        = (state == S_REQ) & ~cancel_r & ~misaligned & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      pc_r     <= RESET_PC;
      cancel_r <= 1'b0;
      out_pc   <= RESET_PC;
      out_inst <= 32'd0;
      out_adef <= 1'b0;
    end else begin
      state    <= state_n;
      pc_r     <= pc_n;
      cancel_r <= cancel_n;
      out_pc   <= out_pc_n;
      out_inst <= out_inst_n;
      out_adef <= out_adef_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc_r;
    cancel_n   = cancel_r;
    out_pc_n   = out_pc;
    out_inst_n = out_inst;
    out_adef_n = out_adef;
    unique case (state)
      S_REQ: begin
        if (bus.i_redirect) begin
          pc_n = bus.i_redirect_pc;
          // The old address was already accepted: its data must be dropped.
          if (req & bus.inst_sram_addr_ok) begin
            state_n  = S_WAIT;
            cancel_n = 1'b1;
          end
        end else if (misaligned) begin
          state_n    = S_HOLD;
          out_pc_n   = pc_r;
          out_inst_n = NOP_INST;
          out_adef_n = 1'b1;
        end else if (req & bus.inst_sram_addr_ok) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.inst_sram_data_ok) begin
          if (bus.i_redirect) pc_n = bus.i_redirect_pc;
          if (cancel_r | bus.i_redirect) begin
            cancel_n = 1'b0;
            state_n  = S_REQ;
          end else begin
            out_pc_n   = pc_r;
            out_inst_n = bus.inst_sram_rdata;
            out_adef_n = 1'b0;
            state_n    = S_HOLD;
          end
        end else if (bus.i_redirect) begin
          pc_n     = bus.i_redirect_pc;
          cancel_n = 1'b1;
        end
      end
      S_HOLD: begin
        // A redirect wins even if downstream takes the entry this cycle.
        if (bus.i_redirect) begin
          pc_n    = bus.i_redirect_pc;
          state_n = S_REQ;
        end else if (bus.i_if_ready) begin
          pc_n    = pc_r + 32'd4;
          state_n = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase
  end

  assign bus.inst_sram_req  = req;
  assign bus.inst_sram_addr = pc_r;
  assign bus.o_if_valid     = (state == S_HOLD);
  assign bus.o_if_pc        = out_pc;
  assign bus.o_if_inst      = out_inst;
  assign bus.o_if_adef      = out_adef;
  assign bus.dbg_state      = state;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then randomized traffic, with a
// behavioural SRAM slave and an architectural-PC reference model.
module tb_if_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h1C00_0000;
  localparam logic [31:0] NOP_INST = 32'h0340_0000;
  localparam logic [31:0] STALE    = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_fetch_stage_if bus();
  if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model: architectural fetch PC of the next entry to be presented
  logic [31:0] exp_pc;
  // slave: accepted-but-unanswered request addresses and their stale flags
  logic [31:0] exp_q[$];
  bit          stale_q[$];
  int acc_min, acc_max, dat_min, dat_max, acc_cnt, dat_cnt;
  int n_acc = 0;
  int n_req = 0;
  bit          prev_redir, prev_hold;
  logic [31:0] prev_pc, prev_inst;
  logic        prev_adef;
  int          idle_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1C00_0000) return 32'h0280_0421;
    return (a * 32'h9E37_79B9) ^ 32'h0F0F_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_lat(input int a0, input int a1, input int d0, input int d1);
    acc_min = a0; acc_max = a1; dat_min = d0; dat_max = d1;
    acc_cnt = $urandom_range(acc_max, acc_min);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_if_ready = 1'b0; bus.i_redirect = 1'b0; bus.i_redirect_pc = 32'd0;
    bus.inst_sram_addr_ok = 1'b0; bus.inst_sram_data_ok = 1'b0; bus.inst_sram_rdata = 32'd0;
    #1;
    check("rst_valid", 32'(bus.o_if_valid), 32'd0);
    check("rst_pc", bus.o_if_pc, RESET_PC);
    check("rst_inst", bus.o_if_inst, 32'd0);
    check("rst_adef", 32'(bus.o_if_adef), 32'd0);
    check("rst_req", 32'(bus.inst_sram_req), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    exp_pc = RESET_PC;
    exp_q.delete(); stale_q.delete();
    prev_redir = 1'b0; prev_hold = 1'b0; idle_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: check outputs, answer as the SRAM, drive inputs, advance the model.
  task automatic cycle(input bit redir, input logic [31:0] tgt, input bit rdy);
    logic valid;
    @(negedge clk);
    valid = bus.o_if_valid;
    if (prev_redir) check("valid_after_redirect", 32'(valid), 32'd0);
    if (prev_hold) begin
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_pc", bus.o_if_pc, prev_pc);
      check("hold_inst", bus.o_if_inst, prev_inst);
      check("hold_adef", 32'(bus.o_if_adef), 32'(prev_adef));
    end
    if (valid) begin
      check("entry_pc", bus.o_if_pc, exp_pc);
      check("entry_adef", 32'(bus.o_if_adef), 32'(exp_pc[1:0] != 2'b00));
      check("entry_inst", bus.o_if_inst, (exp_pc[1:0] != 2'b00) ? NOP_INST : mem_word(exp_pc));
      check("no_req_while_valid", 32'(bus.inst_sram_req), 32'd0);
      idle_cnt = 0;
    end else begin
      idle_cnt++;
    end
    if (idle_cnt > 30) begin
      check("fetch_progress", 32'(idle_cnt), 32'd30);
      idle_cnt = 0;
    end
    if (bus.inst_sram_req) begin
      check("req_addr", bus.inst_sram_addr, exp_pc);
      check("req_aligned", 32'(bus.inst_sram_addr[1:0]), 32'd0);
      check("single_outstanding", 32'(exp_q.size()), 32'd0);
      n_req++;
    end
    bus.inst_sram_addr_ok = 1'b0;
    bus.inst_sram_data_ok = 1'b0;
    bus.inst_sram_rdata   = 32'd0;
    if (exp_q.size() != 0) begin
      if (dat_cnt == 0) begin
        bus.inst_sram_data_ok = 1'b1;
        bus.inst_sram_rdata   = stale_q[0] ? STALE : mem_word(exp_q[0]);
        void'(exp_q.pop_front());
        void'(stale_q.pop_front());
      end else dat_cnt--;
    end
    if (bus.inst_sram_req) begin
      if (acc_cnt == 0) begin
        bus.inst_sram_addr_ok = 1'b1;
        exp_q.push_back(bus.inst_sram_addr);
        stale_q.push_back(1'b0);
        n_acc++;
        dat_cnt = $urandom_range(dat_max, dat_min) - 1;
        acc_cnt = $urandom_range(acc_max, acc_min);
      end else acc_cnt--;
    end
    bus.i_redirect    = redir;
    bus.i_redirect_pc = tgt;
    bus.i_if_ready    = rdy;
    prev_hold  = valid & ~rdy & ~redir;
    prev_pc    = bus.o_if_pc;
    prev_inst  = bus.o_if_inst;
    prev_adef  = bus.o_if_adef;
    prev_redir = redir;
    if (redir) begin
      exp_pc = tgt;
      foreach (stale_q[i]) stale_q[i] = 1'b1;
      idle_cnt = 0;
    end else if (valid && rdy) begin
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  // Peek just after the edge; idle one cycle (ready=0) while the event is absent.
  task automatic wait_valid();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.o_if_valid) begin seen = 1'b1; break; end
      cycle(1'b0, 32'd0, 1'b0);
    end
    if (!seen) check("wait_valid_timeout", 32'(bus.o_if_valid), 32'd1);
  endtask

  task automatic wait_req();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.inst_sram_req) begin seen = 1'b1; break; end
      cycle(1'b0, 32'd0, 1'b0);
    end
    if (!seen) check("wait_req_timeout", 32'(bus.inst_sram_req), 32'd1);
  endtask

  initial begin
    int r0, a0;
    logic [31:0] t;
    rst = 1'b1;
    bus.i_if_ready = 1'b0; bus.i_redirect = 1'b0; bus.i_redirect_pc = 32'd0;
    bus.inst_sram_addr_ok = 1'b0; bus.inst_sram_data_ok = 1'b0; bus.inst_sram_rdata = 32'd0;
    set_lat(0, 0, 1, 1);
    do_reset();

    // zero-wait SRAM: first fetch and the following address
    wait_req();
    check("first_addr", bus.inst_sram_addr, 32'h1C00_0000);
    cycle(1'b0, 32'd0, 1'b0);
    wait_valid();
    check("first_pc", bus.o_if_pc, 32'h1C00_0000);
    check("first_inst", bus.o_if_inst, 32'h0280_0421);
    cycle(1'b0, 32'd0, 1'b1);
    wait_req();
    check("next_addr", bus.inst_sram_addr, 32'h1C00_0004);
    cycle(1'b0, 32'd0, 1'b0);

    // downstream stall for 5 cycles
    wait_valid();
    r0 = n_req;
    repeat (5) cycle(1'b0, 32'd0, 1'b0);
    check("stall_no_req", 32'(n_req - r0), 32'd0);
    cycle(1'b0, 32'd0, 1'b1);

    // redirect one cycle after acceptance; stale data arrives later
    set_lat(0, 0, 3, 3);
    wait_req();
    cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b1, 32'h1C00_0100, 1'b0);
    cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0);
    wait_req();
    check("redir_addr", bus.inst_sram_addr, 32'h1C00_0100);
    cycle(1'b0, 32'd0, 1'b0);
    wait_valid();
    check("redir_pc", bus.o_if_pc, 32'h1C00_0100);
    check("stale_hidden", 32'(bus.o_if_inst !== STALE), 32'd1);
    cycle(1'b0, 32'd0, 1'b1);

    // misaligned redirect target
    cycle(1'b1, 32'h1C00_0102, 1'b0);
    r0 = n_req;
    wait_valid();
    check("adef_no_req", 32'(n_req - r0), 32'd0);
    check("adef_flag", 32'(bus.o_if_adef), 32'd1);
    check("adef_pc", bus.o_if_pc, 32'h1C00_0102);
    check("adef_inst", bus.o_if_inst, NOP_INST);
    cycle(1'b1, 32'h1C00_0200, 1'b1);

    // redirect coinciding with data_ok, then redirect in hold with ready
    set_lat(0, 0, 2, 2);
    wait_req();
    check("redir2_addr", bus.inst_sram_addr, 32'h1C00_0200);
    cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b1, 32'h1C00_0300, 1'b0);
    wait_valid();
    check("same_cycle_pc", bus.o_if_pc, 32'h1C00_0300);
    cycle(1'b1, 32'h1C00_0400, 1'b1);
    wait_valid();
    check("hold_redir_pc", bus.o_if_pc, 32'h1C00_0400);
    cycle(1'b0, 32'd0, 1'b1);

    // addr_ok delayed by 4 cycles
    set_lat(4, 4, 1, 1);
    r0 = n_req; a0 = n_acc;
    wait_valid();
    check("slow_req_cycles", 32'(n_req - r0), 32'd5);
    check("slow_accepts", 32'(n_acc - a0), 32'd1);
    check("slow_pc", bus.o_if_pc, 32'h1C00_0404);
    cycle(1'b0, 32'd0, 1'b1);

    // reset while a request is outstanding
    set_lat(0, 0, 3, 3);
    wait_req();
    cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0);
    do_reset();

    // randomized traffic
    set_lat(0, 3, 1, 3);
    for (int i = 0; i < 1500; i++) begin
      t = $urandom();
      case ($urandom_range(0, 7))
        0: ;
        1: t = 32'hFFFF_FFF4;
        default: t[1:0] = 2'b00;
      endcase
      cycle($urandom_range(0, 9) == 0, t, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
